// File: rtl/aes_word_packer_pkg.sv
// Shared types and constants for the AES word packer: block geometry,
// FSM encoding, control/flag bundles and the per-word byte reversal.
package aes_word_packer_pkg;

   localparam int AES_WORD_W  = 32;
   localparam int AES_BLOCK_W = 128;
   localparam int AES_NB_W    = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } packer_state_t;

   typedef struct packed {
      logic                start;
      logic                byte_swap;
      logic [AES_NB_W-1:0] nblocks;
   } ctrl_packer_t;

   typedef struct packed {
      logic                busy;
      logic                done;
      logic [AES_NB_W-1:0] blk_cnt;
      logic                strb_err;
   } flags_packer_t;

   function automatic logic [31:0] bswap32(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

endpackage

// File: rtl/aes_word_packer.sv
// Packs 32-bit stream words into 128-bit AES blocks, word 0 in the LSBs.
// The output register is separate from the assembly register so intake overlaps a stalled consumer.
module aes_word_packer
   import aes_word_packer_pkg::*;
#(
   parameter int WORD_W  = AES_WORD_W,
   parameter int BLOCK_W = AES_BLOCK_W,
   parameter int NB_W    = AES_NB_W
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                clear_i,
   input  logic                start_i,
   input  logic [NB_W-1:0]     nblocks_i,
   input  logic                byte_swap_i,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  logic [WORD_W-1:0]   in_data_i,
   input  logic [WORD_W/8-1:0] in_strb_i,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic [BLOCK_W-1:0]  out_data_o,
   output logic                busy_o,
   output logic                done_o,
   output logic [NB_W-1:0]     blk_cnt_o,
   output logic                strb_err_o
);

   localparam int WPB   = BLOCK_W / WORD_W;
   localparam int WC_W  = (WPB > 1) ? $clog2(WPB) : 1;
   localparam int ASM_W = BLOCK_W - WORD_W;
   localparam logic [WC_W-1:0] LAST_WORD = WC_W'(WPB - 1);

   packer_state_t      state_q, state_d;
   logic [WC_W-1:0]    wcnt_q, wcnt_d;
   logic [NB_W-1:0]    blk_in_q, blk_in_d;
   logic [NB_W-1:0]    blk_cnt_q, blk_cnt_d;
   logic [NB_W-1:0]    nblocks_q, nblocks_d;
   logic               swap_q, swap_d;
   logic [ASM_W-1:0]   asm_q, asm_d;
   logic               out_valid_q, out_valid_d;
   logic [BLOCK_W-1:0] out_data_q, out_data_d;
   logic               strb_err_q, strb_err_d;

   ctrl_packer_t       ctrl;
   flags_packer_t      flags;
   logic [WORD_W-1:0]  word_in;
   logic               in_fire, out_fire, last_blk;

   assign ctrl = '{start: start_i, byte_swap: byte_swap_i, nblocks: nblocks_i};

   assign word_in = swap_q ? bswap32(in_data_i) : in_data_i;

   // The last word may only land when the output register is free or being drained this cycle.
   assign in_ready_o = (state_q == RUN) && (blk_in_q < nblocks_q) &&
                       ((wcnt_q != LAST_WORD) || !out_valid_q || out_ready_i);

   assign in_fire  = in_valid_i && in_ready_o;
   assign out_fire = out_valid_q && out_ready_i;
   assign last_blk = (({1'b0, blk_cnt_q} + 1'b1) == {1'b0, nblocks_q});

   always_comb begin
      state_d     = state_q;
      wcnt_d      = wcnt_q;
      blk_in_d    = blk_in_q;
      blk_cnt_d   = blk_cnt_q;
      nblocks_d   = nblocks_q;
      swap_d      = swap_q;
      asm_d       = asm_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      strb_err_d  = strb_err_q;

      case (state_q)
         IDLE: begin
            if (ctrl.start) begin
               nblocks_d  = ctrl.nblocks;
               swap_d     = ctrl.byte_swap;
               wcnt_d     = '0;
               blk_in_d   = '0;
               blk_cnt_d  = '0;
               strb_err_d = 1'b0;
               state_d    = (ctrl.nblocks == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (out_fire) begin
               out_valid_d = 1'b0;
               blk_cnt_d   = blk_cnt_q + 1'b1;
               if (last_blk) state_d = DONE;
            end
            // A last-word accept after the drain above re-arms the output with the new block.
            if (in_fire) begin
               if (in_strb_i != '1) strb_err_d = 1'b1;
               if (wcnt_q == LAST_WORD) begin
                  out_data_d  = {word_in, asm_q};
                  out_valid_d = 1'b1;
                  wcnt_d      = '0;
                  blk_in_d    = blk_in_q + 1'b1;
               end else begin
                  asm_d[wcnt_q*WORD_W +: WORD_W] = word_in;
                  wcnt_d = wcnt_q + 1'b1;
               end
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         state_q     <= IDLE;
         wcnt_q      <= '0;
         blk_in_q    <= '0;
         blk_cnt_q   <= '0;
         nblocks_q   <= '0;
         swap_q      <= 1'b0;
         asm_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         strb_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wcnt_q      <= wcnt_d;
         blk_in_q    <= blk_in_d;
         blk_cnt_q   <= blk_cnt_d;
         nblocks_q   <= nblocks_d;
         swap_q      <= swap_d;
         asm_q       <= asm_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         strb_err_q  <= strb_err_d;
      end
   end

   assign flags = '{busy:     (state_q == RUN),
                    done:     (state_q == DONE),
                    blk_cnt:  blk_cnt_q,
                    strb_err: strb_err_q};

   assign busy_o      = flags.busy;
   assign done_o      = flags.done;
   assign blk_cnt_o   = flags.blk_cnt;
   assign strb_err_o  = flags.strb_err;
   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;

endmodule
